prbs_gen_check: RTL

- Parametrised multi-bit PRBS generator paired with a self-synchronising PRBS checker.
- Generalises the single-output LFSR generator:
  - configurable word width (bits per clock)
  - runtime seed load
  - error injection
  - checker with lock state machine and saturating error counter
- Used for link/DAC/ADC data-path BIST in the RF demo design; generator and checker share polynomial parameters but are independent.

---
 rtl/prbs_gen_check.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/prbs_gen_check.sv
// Multi-bit Fibonacci PRBS generator plus self-synchronising checker with lock FSM
// and saturating error counter. Generator and checker share polynomial parameters only.
module prbs_gen_check #(
   parameter int unsigned            g_length     = 16,
   parameter logic [g_length-1:0]    g_taps       = 16'hb400,
   parameter int unsigned            g_width      = 4,
   parameter logic [g_length-1:0]    g_init_value = 16'hace1,
   parameter int unsigned            g_lock_words = 8,
   parameter int unsigned            g_loss_bits  = 4,
   parameter int unsigned            g_cnt_width  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   gen_enable_i,
   input  logic                   seed_load_i,
   input  logic [g_length-1:0]    seed_i,
   input  logic                   inject_err_i,
   output logic [g_width-1:0]     gen_data_o,
   output logic                   gen_valid_o,
   input  logic                   chk_valid_i,
   input  logic [g_width-1:0]     chk_data_i,
   input  logic                   chk_cnt_clear_i,
   output logic                   chk_locked_o,
   output logic                   chk_err_o,
   output logic [g_cnt_width-1:0] chk_err_cnt_o
);

   localparam int unsigned ErrW     = $clog2(g_width + 1);
   localparam int unsigned BitCntW  = $clog2(g_length + g_width + 1);
   localparam int unsigned WordCntW = $clog2(g_lock_words + 1);
   localparam int unsigned SumW     = ((g_cnt_width > ErrW) ? g_cnt_width : ErrW) + 1;
   localparam logic [g_cnt_width-1:0] CntMax = '1;

   localparam logic [1:0] StSeek   = 2'd0;
   localparam logic [1:0] StVerify = 2'd1;
   localparam logic [1:0] StLocked = 2'd2;

   // ---------------- generator ----------------
   logic [g_length-1:0] gen_q, gen_d, gen_walk;
   logic [g_width-1:0]  gen_word, gen_data_q, gen_data_d;
   logic                gen_valid_q, gen_valid_d;

   always_comb begin
      gen_walk = gen_q;
      gen_word = '0;
      for (int unsigned k = 0; k < g_width; k++) begin
         gen_word[g_width-1-k] = ^(gen_walk & g_taps);
         gen_walk = {gen_walk[g_length-2:0], gen_word[g_width-1-k]};
      end
   end

   always_comb begin
      gen_d       = gen_q;
      gen_data_d  = gen_data_q;
      gen_valid_d = 1'b0;
      if (seed_load_i) begin
         // An all-zero seed would lock the LFSR up, so fall back to the reset value.
         gen_d = (seed_i == '0) ? g_init_value : seed_i;
      end else if (gen_enable_i) begin
         gen_d                  = gen_walk;
         gen_data_d             = gen_word;
         gen_data_d[g_width-1]  = gen_word[g_width-1] ^ inject_err_i;
         gen_valid_d            = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         gen_q       <= g_init_value;
         gen_data_q  <= '0;
         gen_valid_q <= 1'b0;
      end else begin
         gen_q       <= gen_d;
         gen_data_q  <= gen_data_d;
         gen_valid_q <= gen_valid_d;
      end
   end

   assign gen_data_o  = gen_data_q;
   assign gen_valid_o = gen_valid_q;

   // ---------------- checker ----------------
   logic [1:0]             state_q, state_d;
   logic [g_length-1:0]    chk_q, chk_d, chk_walk;
   logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WordCntW-1:0]    word_cnt_q, word_cnt_d;
   logic                   err_q, err_d;
   logic [g_cnt_width-1:0] cnt_q, cnt_d, cnt_base;
   logic [SumW-1:0]        cnt_sum;
   logic [ErrW-1:0]        bit_errs;
   logic                   exp_bit;

   // In LOCKED the register free-runs on its own predictions (flywheel).
   always_comb begin
      chk_walk = chk_q;
      bit_errs = '0;
      exp_bit  = 1'b0;
      for (int unsigned k = 0; k < g_width; k++) begin
         exp_bit  = ^(chk_walk & g_taps);
         bit_errs = bit_errs + ErrW'(exp_bit ^ chk_data_i[g_width-1-k]);
         chk_walk = {chk_walk[g_length-2:0],
                     (state_q == StLocked) ? exp_bit : chk_data_i[g_width-1-k]};
      end
   end

   always_comb begin
      state_d    = state_q;
      chk_d      = chk_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      err_d      = 1'b0;
      cnt_base   = chk_cnt_clear_i ? '0 : cnt_q;
      cnt_sum    = SumW'(cnt_base) + SumW'(bit_errs);
      cnt_d      = cnt_base;
      if (chk_valid_i) begin
         chk_d = chk_walk;
         case (state_q)
            StSeek: begin
               bit_cnt_d = bit_cnt_q + BitCntW'(g_width);
               if (32'(bit_cnt_d) >= g_length) begin
                  state_d    = StVerify;
                  word_cnt_d = '0;
               end
            end
            StVerify: begin
               if (bit_errs != '0 || chk_walk == '0) begin
                  state_d   = StSeek;
                  bit_cnt_d = '0;
               end else begin
                  word_cnt_d = word_cnt_q + WordCntW'(1);
                  if (32'(word_cnt_d) == g_lock_words) state_d = StLocked;
               end
            end
            StLocked: begin
               if (bit_errs != '0) begin
                  err_d = 1'b1;
                  cnt_d = (cnt_sum > SumW'(CntMax)) ? CntMax : cnt_sum[g_cnt_width-1:0];
                  if (32'(bit_errs) >= g_loss_bits) begin
                     state_d   = StSeek;
                     bit_cnt_d = '0;
                  end
               end
            end
            default: begin
               state_d   = StSeek;
               bit_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= StSeek;
         chk_q      <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         chk_q      <= chk_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign chk_locked_o  = (state_q == StLocked);
   assign chk_err_o     = err_q;
   assign chk_err_cnt_o = cnt_q;

endmodule
